// File: rtl/ptp_pkg.sv
// Shared widths and helpers for the ptp_gearbox narrow/wide width converter.
// Both the pack and unpack paths use these for lane count, counter width and lane mapping.
package ptp_pkg;

  localparam int DEFAULT_NARROW_W = 8;
  localparam int DEFAULT_WIDE_W   = 32;

  function automatic int lanes(input int wide, input int narrow);
    return wide / narrow;
  endfunction

  function automatic int cnt_width(input int n_lanes);
    return (n_lanes > 2) ? $clog2(n_lanes) : 1;
  endfunction

  // Maps a beat's position within a word to the physical lane it occupies.
  function automatic int lane_sel(input int cnt, input int n_lanes, input logic msb_first);
    int idx;
    if (msb_first) begin
      idx = n_lanes - 1 - cnt;
    end else begin
      idx = cnt;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ptp_lane_counter.sv
// Wrapping lane counter used by both gearbox paths.
// Clear and load both restart at lane 0; last_o flags the final lane of a word.
module ptp_lane_counter import ptp_pkg::*; #(
  parameter int LANES = 4,
  parameter int CNT_W = cnt_width(LANES)
) (
  input  logic             clock,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_s;

  assign last_s = (cnt_q == CNT_W'(LANES - 1));
  assign cnt_o  = cnt_q;
  assign last_o = last_s;

  // Next count: restart takes priority over increment, increment wraps after the last lane.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || load_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (last_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ptp_gearbox.sv
// Bidirectional narrow<->wide width converter with valid/ready on both sides.
// Pack path assembles narrow beats into wide words; unpack path serialises wide words into beats.
module ptp_gearbox import ptp_pkg::*; #(
  parameter int NARROW_W = DEFAULT_NARROW_W,
  parameter int WIDE_W   = DEFAULT_WIDE_W
) (
  input  logic                clock,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                msb_first_i,
  input  logic [NARROW_W-1:0] pk_data_i,
  input  logic                pk_valid_i,
  output logic                pk_ready_o,
  output logic [WIDE_W-1:0]   pk_word_o,
  output logic                pk_valid_o,
  input  logic                pk_ready_i,
  input  logic [WIDE_W-1:0]   up_word_i,
  input  logic                up_valid_i,
  output logic                up_ready_o,
  output logic [NARROW_W-1:0] up_data_o,
  output logic                up_valid_o,
  input  logic                up_ready_i,
  output logic                up_last_o
);

  localparam int LANES = lanes(WIDE_W, NARROW_W);
  localparam int CNT_W = cnt_width(LANES);

  if (((WIDE_W % NARROW_W) != 0) || (LANES < 2)) begin : g_bad_widths
    $error("ptp_gearbox: WIDE_W must be a multiple of NARROW_W giving at least two lanes");
  end

  logic [CNT_W-1:0]  pk_cnt_s;
  logic              pk_last_s;
  logic              pk_accept_s;
  logic              pk_order_s;
  logic              pk_order_q, pk_order_d;
  logic [WIDE_W-1:0] pk_asm_q, pk_asm_d;
  logic [WIDE_W-1:0] pk_word_q, pk_word_d;
  logic [WIDE_W-1:0] pk_full_s;
  logic              pk_valid_q, pk_valid_d;
  int                pk_lane_s;

  logic [CNT_W-1:0]  up_cnt_s;
  logic              up_last_s;
  logic              up_load_s;
  logic              up_beat_s;
  logic              up_order_q, up_order_d;
  logic [WIDE_W-1:0] up_word_q, up_word_d;
  logic              up_valid_q, up_valid_d;
  int                up_lane_s;

  // Only the final beat of a word can stall, and only while the previous word is still held.
  assign pk_ready_o  = !(pk_last_s && pk_valid_q && !pk_ready_i);
  assign pk_accept_s = pk_valid_i && pk_ready_o && !clear_i;
  assign pk_order_s  = (pk_cnt_s == '0) ? msb_first_i : pk_order_q;
  assign pk_word_o   = pk_word_q;
  assign pk_valid_o  = pk_valid_q;

  ptp_lane_counter #(.LANES(LANES), .CNT_W(CNT_W)) u_pk_cnt (
    .clock     (clock),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_i),
    .load_i    (1'b0),
    .inc_i     (pk_accept_s),
    .cnt_o     (pk_cnt_s),
    .last_o    (pk_last_s)
  );

  // Pack path: drop the accepted beat into its lane and publish the word on its last beat.
  always_comb begin
    pk_lane_s = lane_sel(int'(pk_cnt_s), LANES, pk_order_s);
    pk_full_s = pk_asm_q;
    pk_full_s[pk_lane_s*NARROW_W +: NARROW_W] = pk_data_i;
    pk_asm_d   = pk_asm_q;
    pk_order_d = pk_order_q;
    pk_word_d  = pk_word_q;
    pk_valid_d = pk_valid_q;
    if (clear_i) begin
      pk_asm_d   = '0;
      pk_valid_d = 1'b0;
    end else begin
      if (pk_valid_q && pk_ready_i) begin
        pk_valid_d = 1'b0;
      end else begin
        pk_valid_d = pk_valid_q;
      end
      if (pk_accept_s) begin
        pk_asm_d   = pk_full_s;
        pk_order_d = pk_order_s;
        if (pk_last_s) begin
          pk_word_d  = pk_full_s;
          pk_valid_d = 1'b1;
        end else begin
          pk_word_d = pk_word_q;
        end
      end else begin
        pk_asm_d = pk_asm_q;
      end
    end
  end

  // A new word loads on the same edge as the final-lane transfer, so words run back to back.
  assign up_ready_o = !up_valid_q || (up_ready_i && up_last_s);
  assign up_load_s  = up_valid_i && up_ready_o && !clear_i;
  assign up_beat_s  = up_valid_q && up_ready_i && !clear_i;
  assign up_valid_o = up_valid_q;
  assign up_last_o  = up_valid_q && up_last_s;

  ptp_lane_counter #(.LANES(LANES), .CNT_W(CNT_W)) u_up_cnt (
    .clock     (clock),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_i),
    .load_i    (up_load_s),
    .inc_i     (up_beat_s),
    .cnt_o     (up_cnt_s),
    .last_o    (up_last_s)
  );

  // Unpack path: word/order capture and beat-valid tracking.
  always_comb begin
    up_word_d  = up_word_q;
    up_order_d = up_order_q;
    up_valid_d = up_valid_q;
    if (clear_i) begin
      up_valid_d = 1'b0;
    end else if (up_load_s) begin
      up_word_d  = up_word_i;
      up_order_d = msb_first_i;
      up_valid_d = 1'b1;
    end else if (up_beat_s && up_last_s) begin
      up_valid_d = 1'b0;
    end else begin
      up_valid_d = up_valid_q;
    end
  end

  // Output beat selection straight from the registered word.
  always_comb begin
    up_lane_s = lane_sel(int'(up_cnt_s), LANES, up_order_q);
    up_data_o = up_word_q[up_lane_s*NARROW_W +: NARROW_W];
  end

  // Pack and unpack state registers.
  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pk_asm_q   <= '0;
      pk_order_q <= 1'b0;
      pk_word_q  <= '0;
      pk_valid_q <= 1'b0;
      up_word_q  <= '0;
      up_order_q <= 1'b0;
      up_valid_q <= 1'b0;
    end else begin
      pk_asm_q   <= pk_asm_d;
      pk_order_q <= pk_order_d;
      pk_word_q  <= pk_word_d;
      pk_valid_q <= pk_valid_d;
      up_word_q  <= up_word_d;
      up_order_q <= up_order_d;
      up_valid_q <= up_valid_d;
    end
  end

endmodule

// File: tb/tb_ptp_gearbox.sv
// Self-checking bench for ptp_gearbox: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_ptp_gearbox;

  localparam int NW    = 8;
  localparam int WW    = 32;
  localparam int LANES = WW / NW;

  logic          clock = 1'b0;
  logic          reset_n_i;
  logic          clear_i;
  logic          msb_first_i;
  logic [NW-1:0] pk_data_i;
  logic          pk_valid_i;
  logic          pk_ready_o;
  logic [WW-1:0] pk_word_o;
  logic          pk_valid_o;
  logic          pk_ready_i;
  logic [WW-1:0] up_word_i;
  logic          up_valid_i;
  logic          up_ready_o;
  logic [NW-1:0] up_data_o;
  logic          up_valid_o;
  logic          up_ready_i;
  logic          up_last_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: beats of the word being packed, the published word,
  // and the beats still to be emitted for the current unpack word (in output order).
  logic [NW-1:0] pk_part[$];
  logic          pk_part_msb;
  logic          m_pk_valid;
  logic [WW-1:0] m_pk_word;
  logic [NW-1:0] up_q[$];
  logic          last_pk_xfer;
  logic          last_up_acc;
  logic          last_clear;

  logic [NW-1:0] beats[4];

  ptp_gearbox #(.NARROW_W(NW), .WIDE_W(WW)) dut (
    .clock       (clock),
    .reset_n_i   (reset_n_i),
    .clear_i     (clear_i),
    .msb_first_i (msb_first_i),
    .pk_data_i   (pk_data_i),
    .pk_valid_i  (pk_valid_i),
    .pk_ready_o  (pk_ready_o),
    .pk_word_o   (pk_word_o),
    .pk_valid_o  (pk_valid_o),
    .pk_ready_i  (pk_ready_i),
    .up_word_i   (up_word_i),
    .up_valid_i  (up_valid_i),
    .up_ready_o  (up_ready_o),
    .up_data_o   (up_data_o),
    .up_valid_o  (up_valid_o),
    .up_ready_i  (up_ready_i),
    .up_last_o   (up_last_o)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pk_part.delete();
    up_q.delete();
    pk_part_msb  = 1'b0;
    m_pk_valid   = 1'b0;
    m_pk_word    = '0;
    last_pk_xfer = 1'b0;
    last_up_acc  = 1'b0;
    last_clear   = 1'b0;
  endtask

  // Called just after a falling edge with inputs set: compare, advance the model, wait a cycle.
  task automatic step();
    logic          exp_pk_rdy;
    logic          exp_up_rdy;
    logic          pk_xfer;
    logic          up_acc;
    logic          up_beat;
    logic [WW-1:0] w;
    int            lane;
    #1;
    exp_pk_rdy = !((pk_part.size() == LANES - 1) && m_pk_valid && !pk_ready_i);
    exp_up_rdy = (up_q.size() == 0) || (up_ready_i && (up_q.size() == 1));
    chk_b("pk_ready", pk_ready_o, exp_pk_rdy);
    chk_b("pk_valid", pk_valid_o, m_pk_valid);
    if (m_pk_valid) chk("pk_word", pk_word_o, m_pk_word);
    chk_b("up_ready", up_ready_o, exp_up_rdy);
    chk_b("up_valid", up_valid_o, up_q.size() != 0);
    if (up_q.size() != 0) chk("up_data", WW'(up_data_o), WW'(up_q[0]));
    chk_b("up_last", up_last_o, up_q.size() == 1);

    pk_xfer = pk_valid_i && exp_pk_rdy && !clear_i;
    up_acc  = up_valid_i && exp_up_rdy && !clear_i;
    up_beat = (up_q.size() != 0) && up_ready_i && !clear_i;
    if (clear_i) begin
      pk_part.delete();
      up_q.delete();
      m_pk_valid = 1'b0;
    end else begin
      if (m_pk_valid && pk_ready_i) m_pk_valid = 1'b0;
      if (pk_xfer) begin
        if (pk_part.size() == 0) pk_part_msb = msb_first_i;
        pk_part.push_back(pk_data_i);
        if (pk_part.size() == LANES) begin
          w = '0;
          for (int i = 0; i < LANES; i++) begin
            lane = pk_part_msb ? (LANES - 1 - i) : i;
            w = w | (WW'(pk_part[i]) << (lane * NW));
          end
          m_pk_word  = w;
          m_pk_valid = 1'b1;
          pk_part.delete();
        end
      end
      if (up_beat) void'(up_q.pop_front());
      if (up_acc) begin
        for (int i = 0; i < LANES; i++) begin
          lane = msb_first_i ? (LANES - 1 - i) : i;
          up_q.push_back(NW'(up_word_i >> (lane * NW)));
        end
      end
    end
    last_pk_xfer = pk_xfer;
    last_up_acc  = up_acc;
    last_clear   = clear_i;
    @(negedge clock);
  endtask

  task automatic pk_beat(input logic [NW-1:0] d, input logic msb);
    pk_valid_i  = 1'b1;
    pk_data_i   = d;
    msb_first_i = msb;
    step();
  endtask

  task automatic drive_random();
    clear_i     = ($urandom_range(0, 49) == 0);
    msb_first_i = 1'($urandom_range(0, 1));
    pk_ready_i  = ($urandom_range(0, 3) != 0);
    up_ready_i  = ($urandom_range(0, 3) != 0);
    if (!(pk_valid_i && !last_pk_xfer && !last_clear)) begin
      pk_valid_i = ($urandom_range(0, 3) != 0);
      pk_data_i  = NW'($urandom);
    end
    if (!(up_valid_i && !last_up_acc && !last_clear)) begin
      up_valid_i = ($urandom_range(0, 2) == 0);
      up_word_i  = $urandom;
    end
  endtask

  initial begin
    reset_n_i   = 1'b0;
    clear_i     = 1'b0;
    msb_first_i = 1'b0;
    pk_data_i   = '0;
    pk_valid_i  = 1'b0;
    pk_ready_i  = 1'b0;
    up_word_i   = '0;
    up_valid_i  = 1'b0;
    up_ready_i  = 1'b0;
    model_reset();

    #2;
    chk("rst_pk_word", pk_word_o, 32'h0);
    chk_b("rst_pk_valid", pk_valid_o, 1'b0);
    chk_b("rst_pk_ready", pk_ready_o, 1'b1);
    chk("rst_up_data", WW'(up_data_o), 32'h0);
    chk_b("rst_up_valid", up_valid_o, 1'b0);
    chk_b("rst_up_last", up_last_o, 1'b0);
    chk_b("rst_up_ready", up_ready_o, 1'b1);
    @(negedge clock);
    reset_n_i  = 1'b1;
    pk_ready_i = 1'b1;
    up_ready_i = 1'b1;

    // Pack, LSB-first
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) pk_beat(beats[i], 1'b0);
    pk_valid_i = 1'b0;
    chk("lsb_word", pk_word_o, 32'h44332211);
    chk_b("lsb_valid", pk_valid_o, 1'b1);
    step();
    chk_b("lsb_valid_one_cycle", pk_valid_o, 1'b0);

    // Pack, MSB-first with the order input toggling mid-word
    for (int i = 0; i < 4; i++) pk_beat(beats[i], 1'((i == 0) || (i == 2)));
    pk_valid_i = 1'b0;
    chk("msb_word", pk_word_o, 32'h11223344);
    step();

    // Pack stall while the previous word is held
    pk_ready_i = 1'b0;
    beats = '{8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 4; i++) pk_beat(beats[i], 1'b0);
    pk_valid_i = 1'b0;
    chk("stall_held_word", pk_word_o, 32'hA0A1A2A3);
    for (int i = 0; i < 4; i++) begin
      pk_valid_i = 1'b1;
      pk_data_i  = 8'hB0 + 8'(i);
      #1;
      chk_b("stall_ready", pk_ready_o, i < 3);
      step();
    end
    #1;
    chk_b("stall_ready_hold", pk_ready_o, 1'b0);
    chk("stall_word_hold", pk_word_o, 32'hA0A1A2A3);
    step();
    pk_ready_i = 1'b1;
    #1;
    chk_b("stall_release_ready", pk_ready_o, 1'b1);
    step();
    pk_valid_i = 1'b0;
    chk("stall_new_word", pk_word_o, 32'hB3B2B1B0);
    chk_b("stall_new_valid", pk_valid_o, 1'b1);
    step();

    // Unpack with alternating back-pressure and a back-to-back second word
    up_ready_i  = 1'b0;
    up_valid_i  = 1'b1;
    up_word_i   = 32'hDEADBEEF;
    msb_first_i = 1'b0;
    step();
    up_valid_i = 1'b0;
    beats = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int k = 0; k < 4; k++) begin
      up_ready_i = 1'b0;
      #1;
      chk("up_hold_data", WW'(up_data_o), WW'(beats[k]));
      chk_b("up_hold_last", up_last_o, k == 3);
      step();
      up_ready_i = 1'b1;
      if (k == 3) begin
        up_valid_i = 1'b1;
        up_word_i  = 32'hCAFEF00D;
      end
      #1;
      chk("up_xfer_data", WW'(up_data_o), WW'(beats[k]));
      if (k == 3) chk_b("up_b2b_ready", up_ready_o, 1'b1);
      step();
    end
    up_valid_i = 1'b0;
    chk("up_second_first_beat", WW'(up_data_o), 32'h0D);
    chk_b("up_second_valid", up_valid_o, 1'b1);
    repeat (4) step();
    chk_b("up_drained", up_valid_o, 1'b0);

    // Clear drops a partial word and the beat offered alongside it
    pk_beat(8'h01, 1'b0);
    pk_beat(8'h02, 1'b0);
    clear_i    = 1'b1;
    pk_valid_i = 1'b1;
    pk_data_i  = 8'h99;
    step();
    clear_i = 1'b0;
    for (int i = 0; i < 4; i++) pk_beat(8'h05 + 8'(i), 1'b0);
    pk_valid_i = 1'b0;
    chk("clear_word", pk_word_o, 32'h08070605);
    step();

    // Asynchronous reset between edges with both paths busy
    pk_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) pk_beat(8'h21 + 8'(i), 1'b0);
    pk_beat(8'h31, 1'b0);
    pk_beat(8'h32, 1'b0);
    pk_valid_i = 1'b0;
    up_ready_i = 1'b0;
    up_valid_i = 1'b1;
    up_word_i  = 32'h12345678;
    step();
    up_valid_i = 1'b0;
    chk_b("pre_rst_pk_valid", pk_valid_o, 1'b1);
    chk_b("pre_rst_up_valid", up_valid_o, 1'b1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_b("async_rst_pk_valid", pk_valid_o, 1'b0);
    chk_b("async_rst_up_valid", up_valid_o, 1'b0);
    model_reset();
    @(negedge clock);
    reset_n_i  = 1'b1;
    pk_ready_i = 1'b1;
    up_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) pk_beat(8'hC1 + 8'(i), 1'b0);
    pk_valid_i = 1'b0;
    chk("post_rst_pk_word", pk_word_o, 32'hC4C3C2C1);
    up_valid_i  = 1'b1;
    up_word_i   = 32'h87654321;
    msb_first_i = 1'b1;
    step();
    up_valid_i = 1'b0;
    chk("post_rst_up_first", WW'(up_data_o), 32'h87);
    repeat (4) step();

    // Randomized traffic against the reference model
    repeat (3000) begin
      drive_random();
      step();
    end
    clear_i    = 1'b0;
    pk_valid_i = 1'b0;
    up_valid_i = 1'b0;
    pk_ready_i = 1'b1;
    up_ready_i = 1'b1;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ptp_gearbox.md
# ptp_gearbox

Parametrised bidirectional width converter between the chip's narrow I/O lanes and the core's wide memory and data words. It succeeds the fixed 8↔32 packers: both widths and the lane order are configurable, and both paths use valid/ready handshakes with back-pressure. The pack path turns a narrow beat stream into wide words. The unpack path serialises wide words into narrow beats. Both paths run at full throughput with no bubble between words.

## Interface
- `NARROW_W`, 8, narrow lane width in bits.
- `WIDE_W`, 32, wide word width in bits. Must be an integer multiple of `NARROW_W`, with `LANES = WIDE_W/NARROW_W >= 2`. Any other combination is an elaboration error.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `clear_i`  in  1  synchronous flush of both paths.
- `msb_first_i`  in  1  lane order: 1 means the first beat maps to the top lane; 0 means the first beat maps to lane 0.
- `pk_data_i`  in  NARROW_W  pack-path input beat.
- `pk_valid_i`  in  1  pack-path input valid.
- `pk_ready_o`  out  1  pack-path input ready.
- `pk_word_o`  out  WIDE_W  assembled wide word.
- `pk_valid_o`  out  1  assembled word valid.
- `pk_ready_i`  in  1  downstream ready for the assembled word.
- `up_word_i`  in  WIDE_W  unpack-path input word.
- `up_valid_i`  in  1  unpack-path input valid.
- `up_ready_o`  out  1  unpack-path input ready.
- `up_data_o`  out  NARROW_W  unpack-path output beat.
- `up_valid_o`  out  1  output beat valid.
- `up_ready_i`  in  1  downstream ready for the output beat.
- `up_last_o`  out  1  high while the final lane of a word is presented.

## Operation
- **Handshake rule:** a transfer occurs on any edge where valid and ready are both 1. Once valid is asserted, it and its data stay stable until the transfer.
- **Pack path state:** an assembly register, lane counter `pk_cnt` (0..LANES-1), latched order bit, and an output register with `pk_valid_o`.
  - The order bit is latched from `msb_first_i` when a beat is accepted with `pk_cnt==0`.
  - An accepted beat is written to lane `pk_cnt` (LSB-first) or lane `LANES-1-pk_cnt` (MSB-first). `pk_cnt` then increments and wraps to 0 after the last lane.
  - On acceptance of the last beat, the full word (including that beat) moves to the output register and `pk_valid_o` sets.
  - `pk_ready_o = !(pk_cnt==LANES-1 && pk_valid_o && !pk_ready_i)`. Only the last beat can stall, and only while the previous word is still held.
  - `pk_valid_o` clears when the word is consumed and no new word completes on the same edge.
- **Unpack path state:** a word register, lane counter `up_cnt`, latched order bit, and `up_valid_o`.
  - `up_ready_o = !up_valid_o || (up_ready_i && up_cnt==LANES-1)`.
  - On word acceptance: the word is loaded, the order bit is latched, `up_cnt` is set to 0 and `up_valid_o` is set to 1.
  - `up_data_o` is lane `up_cnt` (LSB-first) or lane `LANES-1-up_cnt` (MSB-first), selected combinationally.
  - `up_last_o = up_valid_o && up_cnt==LANES-1`.
  - Each beat transfer increments `up_cnt`. After the final beat, `up_valid_o` clears unless a new word is accepted on the same edge.
- **`clear_i`:** zeroes both counters and both valid flags and discards partial words. It overrides any handshake on the same edge; beats or words offered in that cycle are dropped.
- **Reset values:** all registers are 0, so `pk_word_o=0`, `pk_valid_o=0`, `up_data_o=0`, `up_valid_o=0`, `up_last_o=0`, `pk_ready_o=1`, `up_ready_o=1`.

## Timing
- **Pack latency:** `pk_valid_o` rises the cycle after the last beat is accepted. Sustained throughput is one beat per cycle with `pk_ready_i=1`.
- **Unpack latency:** the first beat is valid the cycle after the word is accepted. A new word is accepted on the same edge as the final-lane transfer, so there is no idle cycle between words.
- **Ready outputs:** combinational from registered state and the downstream ready inputs. There is no combinational path from any input data to any output data.
- **Asynchronous reset:** asserting `reset_n_i` mid-word forces both valid outputs low immediately, with no clock edge required. After deassertion, the first word starts at lane count 0.

## Structure
- The shared package `ptp_pkg` holds:
  - the default widths (8, 32);
  - a `lanes(wide, narrow)` constant function;
  - the `$clog2`-based counter width;
  - a lane-select function shared by both paths.
- One sub-module, `ptp_lane_counter`, is instantiated once per path. It provides the wrapping counter with increment, clear and last-lane flag.
- The pack and unpack datapaths live inline in `ptp_gearbox`.

## Test plan
All scenarios use the defaults (`NARROW_W=8`, `WIDE_W=32`).
- **Pack, LSB-first:** `msb_first_i=0`, beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `pk_ready_i=1` -> `pk_word_o=0x44332211` with `pk_valid_o` high for one cycle, starting the cycle after the 4th beat.
- **Pack, MSB-first:** same beats with `msb_first_i=1` -> `pk_word_o=0x11223344`. Toggling `msb_first_i` mid-word has no effect on that word.
- **Pack stall:** `pk_ready_i=0` holding word 0xA0A1A2A3, then 4 further beats -> 3 beats accepted, `pk_ready_o=0` on the 4th. One cycle after `pk_ready_i` rises, the stalled beat is accepted, completing the new word.
- **Unpack with back-pressure:** word 0xDEADBEEF LSB-first, `up_ready_i` alternating 1/0 -> beats EF, BE, AD, DE, each held stable while stalled, with `up_last_o` on DE. A second word (0xCAFEF00D) accepted on the DE edge produces 0D on the next cycle.
- **Clear:** `clear_i` after 2 pack beats (0x01, 0x02), then beats 0x05–0x08 -> `pk_word_o=0x08070605`. A beat offered in the `clear_i` cycle is dropped.
- **Asynchronous reset:** `reset_n_i` pulled low between clock edges during an unpack word -> `up_valid_o` and `pk_valid_o` fall immediately. After release, words restart from lane 0.
